// File: rtl/soc_log_pkg.sv
// soc_log_pkg: shared types and width helpers for the sample log writer.
//   state_e    : controller states (idle, logging, full, dumping)
//   cnt_width  : width of a counter able to hold 0..2**aw
//   ptr_width  : width of a pointer into a 2**aw deep log
package soc_log_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOG  = 2'd1,
    ST_FULL = 2'd2,
    ST_DUMP = 2'd3
  } state_e;

  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int ptr_width(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/log_ram.sv
// log_ram: simple dual-port sample store.
//   clk           : clock
//   we/waddr/wdata: synchronous write port
//   re/raddr      : read request; rdata is registered and valid the cycle after re
// The array has no reset; rdata holds its value when re is low.
module log_ram #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/soc_log_writer.sv
// soc_log_writer: captures a stream of sample words into a RAM log and
// streams it back out, oldest first, on request.
//   clk, rst                      : clock, asynchronous active-high reset
//   start / stop / dump           : one-cycle control pulses
//   in_valid / in_data / in_ready : capture stream
//   out_valid / out_data / out_last / out_ready : dump stream
//   count                         : words held (0..DEPTH)
//   busy / overflow               : not idle / oldest data overwritten (WRAP=1)
module soc_log_writer
  import soc_log_pkg::*;
#(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 10,
  parameter int WRAP    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               dump,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   count,
  output logic               busy,
  output logic               overflow
);

  localparam int CW = cnt_width(A_WIDTH);
  localparam int PW = ptr_width(A_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [CW-1:0] DEPTH_M1 = {1'b0, {A_WIDTH{1'b1}}};
  localparam logic [CW-1:0] CNT_ONE = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, left_q, left_d;
  logic ovf_q, ovf_d;
  // pend: a RAM read issued last cycle, its word is on ram_rdata now
  logic pend_q, pend_d, pend_last_q, pend_last_d;
  // head (h*) drives the outputs; skid (s*) absorbs the in-flight word on a stall
  logic hv_q, hv_d, hl_q, hl_d, sv_q, sv_d, sl_q, sl_d;
  logic [D_WIDTH-1:0] hd_q, hd_d, sd_q, sd_d;

  logic accept, pop, issue, dump_go;
  logic [1:0] lvl;
  logic [D_WIDTH-1:0] ram_rdata;

  assign in_ready = (state_q == ST_LOG) && ((WRAP != 0) || (count_q != DEPTH_C));
  assign accept   = in_valid & in_ready;
  assign pop      = hv_q & out_ready;
  // Words held or in flight after this cycle's pop; a new read is only
  // launched if it is guaranteed a slot even if the consumer stalls next cycle.
  assign lvl      = {1'b0, hv_q} + {1'b0, sv_q} + {1'b0, pend_q};
  assign issue    = (state_q == ST_DUMP) && (left_q != '0) && ((lvl - {1'b0, pop}) <= 2'd1);

  log_ram #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_ram (
    .clk  (clk),
    .we   (accept),
    .waddr(wr_ptr_q),
    .wdata(in_data),
    .re   (issue),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    ovf_d = ovf_q;
    left_d = left_q;
    pend_d = 1'b0;
    pend_last_d = pend_last_q;
    hv_d = hv_q; hd_d = hd_q; hl_d = hl_q;
    sv_d = sv_q; sd_d = sd_q; sl_d = sl_q;
    dump_go = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOG;
          wr_ptr_d = '0;
          count_d = '0;
          ovf_d = 1'b0;
        end else if (dump && (count_q != '0)) begin
          dump_go = 1'b1;
        end
      end
      ST_LOG: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (count_q != DEPTH_C) count_d = count_q + CNT_ONE;
          else ovf_d = 1'b1;
        end
        if (stop) state_d = ST_IDLE;
        else if (accept && (WRAP == 0) && (count_q == DEPTH_M1)) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (dump) dump_go = 1'b1;
      end
      ST_DUMP: begin
        if (issue) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          left_d = left_q - CNT_ONE;
          pend_d = 1'b1;
          pend_last_d = (left_q == CNT_ONE);
        end
        if (pop && hl_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Oldest word sits count entries behind the write pointer (mod DEPTH).
    if (dump_go) begin
      state_d = ST_DUMP;
      rd_ptr_d = wr_ptr_q - count_q[A_WIDTH-1:0];
      left_d = count_q;
    end

    if (pop) hv_d = 1'b0;
    if (!hv_d && sv_q) begin
      hv_d = 1'b1; hd_d = sd_q; hl_d = sl_q;
      sv_d = 1'b0;
    end
    if (pend_q) begin
      if (!hv_d) begin
        hv_d = 1'b1; hd_d = ram_rdata; hl_d = pend_last_q;
      end else begin
        sv_d = 1'b1; sd_d = ram_rdata; sl_d = pend_last_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      left_q <= '0;
      pend_q <= 1'b0;
      pend_last_q <= 1'b0;
      hv_q <= 1'b0; hd_q <= '0; hl_q <= 1'b0;
      sv_q <= 1'b0; sd_q <= '0; sl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      left_q <= left_d;
      pend_q <= pend_d;
      pend_last_q <= pend_last_d;
      hv_q <= hv_d; hd_q <= hd_d; hl_q <= hl_d;
      sv_q <= sv_d; sd_q <= sd_d; sl_q <= sl_d;
    end
  end

  assign out_valid = hv_q;
  assign out_data  = hd_q;
  assign out_last  = hl_q;
  assign count     = count_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = ovf_q;

endmodule
